// File: rtl/tx_arb_pkg.sv
// Shared definitions for the UART transmit frame arbiter: FSM encoding and
// parameter defaults/limits used by tx_frame_arbiter and its sub-blocks.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam int LEN_W_DEFAULT = 8;
  localparam int NUM_REQ_MIN   = 2;
  localparam int NUM_REQ_MAX   = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request bit at or above the
// pointer, wrapping around to bit 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_cand;

  // NOTE: every variable driven here is given a default before the loop, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = i_ptr;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
      w_cand = (w_cand == IDX_W'(NUM_REQ - 1)) ? '0 : w_cand + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin frame scheduler in front of the UART transmit FIFO: grants one
// requester, streams its whole frame while honouring the FIFO full flag.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = LEN_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         p_Req_i,
  input  logic [NUM_REQ*LEN_W-1:0]   FrameLen_i,
  input  logic [NUM_REQ*8-1:0]       ReqData_i,
  output logic [NUM_REQ-1:0]         p_DataAck_o,
  output logic [NUM_REQ-1:0]         p_Gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] Owner_o,
  output logic                       p_Busy_o,
  output logic                       p_FrameDone_o,
  output logic [7:0]                 TxData_o,
  output logic                       n_TxWe_o,
  input  logic                       p_TxFull_i
);

  localparam int OWN_W = $clog2(NUM_REQ);

  arb_state_t         r_state, w_state_next;
  logic [OWN_W-1:0]   r_owner, w_owner_next;
  logic [OWN_W-1:0]   r_rr_ptr;
  logic [LEN_W-1:0]   r_remain, w_remain_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic               r_busy;
  logic               r_frame_done;
  logic [OWN_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic               w_fire;
  logic [7:0]         w_req_data [NUM_REQ];
  logic [LEN_W-1:0]   w_req_len  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign w_req_data[k] = ReqData_i[k*8 +: 8];
    assign w_req_len[k]  = FrameLen_i[k*LEN_W +: LEN_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWN_W)
  ) u_rr_pick (
    .i_req   (p_Req_i),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Gating with rst abandons the frame immediately, even in the reset cycle.
  assign w_fire = (r_state == ST_SEND) && (r_remain != '0) && !p_TxFull_i && !rst;

  always_comb begin
    n_TxWe_o    = 1'b1;
    TxData_o    = 8'h00;
    p_DataAck_o = '0;
    if (w_fire) begin
      n_TxWe_o             = 1'b0;
      TxData_o             = w_req_data[r_owner];
      p_DataAck_o[r_owner] = 1'b1;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_remain_next = r_remain;
    w_gnt_next    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_next  = ST_SEND;
          w_owner_next  = w_pick_idx;
          w_remain_next = w_req_len[w_pick_idx];
        end
      end
      ST_SEND: begin
        if (r_remain == '0) begin
          w_state_next = ST_DONE;
        end else if (w_fire) begin
          w_remain_next = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_state_next != ST_IDLE) w_gnt_next[w_owner_next] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_remain     <= '0;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_remain     <= w_remain_next;
      r_gnt        <= w_gnt_next;
      r_busy       <= (w_state_next != ST_IDLE);
      r_frame_done <= (w_state_next == ST_DONE);
      if (r_state == ST_DONE) begin
        r_rr_ptr <= (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + OWN_W'(1);
      end
    end
  end

  assign p_Gnt_o       = r_gnt;
  assign Owner_o       = r_owner;
  assign p_Busy_o      = r_busy;
  assign p_FrameDone_o = r_frame_done;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: directed scenarios plus random
// traffic, every cycle compared against a frame-level reference model.
module tb_tx_frame_arbiter;

  localparam int NR = 4;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*LW-1:0]  flen = '0;
  logic [NR*8-1:0]   rdata = '0;
  logic              full = 1'b0;
  logic [NR-1:0]     ack, gnt;
  logic [1:0]        owner;
  logic              busy, fdone, nwe;
  logic [7:0]        txd;

  always #5 clk = ~clk;

  tx_frame_arbiter #(.NUM_REQ(NR), .LEN_W(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .p_Req_i       (req),
    .FrameLen_i    (flen),
    .ReqData_i     (rdata),
    .p_DataAck_o   (ack),
    .p_Gnt_o       (gnt),
    .Owner_o       (owner),
    .p_Busy_o      (busy),
    .p_FrameDone_o (fdone),
    .TxData_o      (txd),
    .n_TxWe_o      (nwe),
    .p_TxFull_i    (full)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Requester k's i-th byte; requesters advance on the cycle after an ack.
  int idx [NR];
  function automatic logic [7:0] req_byte(input int k, input int i);
    return 8'(32'hA1 + 48 * k + i);
  endfunction

  // Frame-level reference model.
  bit m_gnt, m_done;
  int m_owner, m_left, m_ptr, m_base, m_sent;

  logic          s_nwe, s_busy, s_done;
  logic [7:0]    s_data;
  logic [NR-1:0] s_ack, s_gnt;
  logic [1:0]    s_owner;

  task automatic model_reset();
    m_gnt = 0; m_done = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_base = 0; m_sent = 0;
    for (int k = 0; k < NR; k++) idx[k] = 0;
  endtask

  task automatic model_check();
    bit fire;
    fire = m_gnt && !m_done && (m_left > 0) && !full;
    check("mdl_gnt",   32'(s_gnt),   m_gnt ? 32'(1 << m_owner) : 32'd0);
    check("mdl_busy",  32'(s_busy),  32'(m_gnt));
    check("mdl_owner", 32'(s_owner), 32'(m_owner));
    check("mdl_done",  32'(s_done),  32'(m_done));
    check("mdl_nwe",   32'(s_nwe),   32'(!fire));
    check("mdl_data",  32'(s_data),  fire ? 32'(req_byte(m_owner, m_base + m_sent)) : 32'd0);
    check("mdl_ack",   32'(s_ack),   fire ? 32'(1 << m_owner) : 32'd0);
  endtask

  task automatic model_advance();
    if (!m_gnt) begin
      for (int off = 0; off < NR; off++) begin
        int c;
        c = (m_ptr + off) % NR;
        if (!m_gnt && req[c]) begin
          m_gnt = 1; m_done = 0; m_owner = c;
          m_left = int'(flen[c*LW +: LW]);
          m_base = idx[c]; m_sent = 0;
        end
      end
    end else if (m_done) begin
      m_gnt = 0; m_done = 0; m_ptr = (m_owner + 1) % NR;
    end else if (m_left == 0) begin
      m_done = 1;
    end else if (!full) begin
      m_left--; m_sent++;
      if (m_left == 0) m_done = 1;
    end
  endtask

  // One clock cycle: drive requester data, sample at negedge, check, advance.
  task automatic step();
    for (int k = 0; k < NR; k++) rdata[k*8 +: 8] = req_byte(k, idx[k]);
    @(negedge clk);
    s_nwe = nwe; s_data = txd; s_ack = ack; s_gnt = gnt;
    s_owner = owner; s_busy = busy; s_done = fdone;
    if (rst) begin
      model_reset();
    end else begin
      model_check();
      model_advance();
      for (int k = 0; k < NR; k++) if (s_ack[k]) idx[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; full = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int order [$];
    logic [NR-1:0] prev;
    logic [7:0] bytes [$];
    int cnt_a, cnt_b, cnt_c, done_k;

    model_reset();
    do_reset();

    // Reset state
    step();
    check("rst_gnt",   32'(s_gnt),   32'd0);
    check("rst_busy",  32'(s_busy),  32'd0);
    check("rst_nwe",   32'(s_nwe),   32'd1);
    check("rst_data",  32'(s_data),  32'd0);
    check("rst_ack",   32'(s_ack),   32'd0);
    check("rst_owner", 32'(s_owner), 32'd0);
    check("rst_done",  32'(s_done),  32'd0);

    // Single 3-byte frame from requester 0
    flen[0 +: LW] = 8'd3; req = 4'b0001;
    step();
    req = '0;
    step(); check("sf_we1", 32'(s_nwe), 32'd0); check("sf_d1", 32'(s_data), 32'hA1);
    check("sf_gnt", 32'(s_gnt), 32'b0001);
    step(); check("sf_we2", 32'(s_nwe), 32'd0); check("sf_d2", 32'(s_data), 32'hA2);
    step(); check("sf_we3", 32'(s_nwe), 32'd0); check("sf_d3", 32'(s_data), 32'hA3);
    step(); check("sf_done", 32'(s_done), 32'd1); check("sf_we4", 32'(s_nwe), 32'd1);
    step(); check("sf_gnt_end", 32'(s_gnt), 32'd0); check("sf_done_end", 32'(s_done), 32'd0);

    // Round-robin: everyone requesting continuously with length 1
    do_reset();
    for (int k = 0; k < NR; k++) flen[k*LW +: LW] = 8'd1;
    req = 4'b1111; prev = '0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (s_gnt != '0 && prev == '0) order.push_back(int'(s_owner));
      prev = s_gnt;
    end
    req = '0;
    repeat (3) step();
    check("rr_frames", 32'(order.size() >= 5), 32'd1);
    if (order.size() >= 5) begin
      check("rr_o0", 32'(order[0]), 32'd0);
      check("rr_o1", 32'(order[1]), 32'd1);
      check("rr_o2", 32'(order[2]), 32'd2);
      check("rr_o3", 32'(order[3]), 32'd3);
      check("rr_o4", 32'(order[4]), 32'd0);
    end
    cnt_a = 0;
    for (int i = 1; i < order.size(); i++) if (order[i] == order[i-1]) cnt_a++;
    check("rr_repeat", 32'(cnt_a), 32'd0);

    // Full stall: 3 full cycles after the 2nd byte of a 4-byte frame
    do_reset();
    flen[0 +: LW] = 8'd4; req = 4'b0001;
    step();
    req = '0; cnt_a = 0; cnt_b = 0; done_k = 0;
    for (int k = 1; k <= 10; k++) begin
      full = (k >= 3 && k <= 5);
      step();
      if (!s_nwe) bytes.push_back(s_data);
      if (full && !s_nwe) cnt_a++;
      if (full && s_ack != '0) cnt_b++;
      if (s_done) done_k = k;
    end
    full = 1'b0;
    check("st_stall_wr",  32'(cnt_a), 32'd0);
    check("st_stall_ack", 32'(cnt_b), 32'd0);
    check("st_nbytes",    32'(bytes.size()), 32'd4);
    for (int i = 0; i < bytes.size() && i < 4; i++) check("st_byte", 32'(bytes[i]), 32'hA1 + 32'(i));
    check("st_done_k", 32'(done_k), 32'd8);

    // Zero-length frame from requester 2
    do_reset();
    flen[2*LW +: LW] = 8'd0; req = 4'b0100;
    step();
    req = '0; cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (s_gnt == 4'b0100) cnt_a++;
      if (!s_nwe) cnt_b++;
      if (s_done) cnt_c++;
    end
    check("zl_gnt_cycles", 32'(cnt_a), 32'd2);
    check("zl_writes",     32'(cnt_b), 32'd0);
    check("zl_done",       32'(cnt_c), 32'd1);
    flen[2*LW +: LW] = 8'd1; flen[3*LW +: LW] = 8'd1; req = 4'b1100;
    step();
    req = '0;
    step();
    check("zl_next_owner", 32'(s_owner), 32'd3);
    check("zl_next_gnt",   32'(s_gnt),   32'b1000);
    repeat (3) step();

    // Reset mid-frame: pointer is advanced first, then a long frame is cut
    do_reset();
    flen[1*LW +: LW] = 8'd1; req = 4'b0010;
    step();
    req = '0;
    repeat (3) step();
    flen[2*LW +: LW] = 8'd10; req = 4'b0100;
    step();
    req = '0; cnt_a = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (!s_nwe) cnt_a++;
    end
    check("rm_bytes", 32'(cnt_a), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rm_nwe",  32'(s_nwe),  32'd1);
    check("rm_gnt",  32'(s_gnt),  32'd0);
    check("rm_busy", 32'(s_busy), 32'd0);
    flen[0 +: LW] = 8'd1; flen[3*LW +: LW] = 8'd1; req = 4'b1001;
    step();
    req = '0;
    step();
    check("rm_owner", 32'(s_owner), 32'd0);
    check("rm_gnt0",  32'(s_gnt),   32'b0001);
    repeat (3) step();

    // Request drop during the 2nd of 5 bytes
    do_reset();
    flen[1*LW +: LW] = 8'd5; req = 4'b0010;
    step();
    cnt_a = 0; done_k = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) req = '0;
      step();
      if (!s_nwe) cnt_a++;
      if (s_done) done_k = k;
    end
    check("rd_writes", 32'(cnt_a), 32'd5);
    check("rd_done_k", 32'(done_k), 32'd6);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(0, 15));
      for (int k = 0; k < NR; k++) flen[k*LW +: LW] = LW'($urandom_range(0, 6));
      full = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; req = '0; full = 1'b0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
